// File: rtl/loader_pkg.sv
// Shared encodings and defaults for the UART instruction loader.
package loader_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        WAIT_LEN,
        RECV,
        WRITE,
        DONE
    } ld_state_t;

endpackage

// File: rtl/uart_inst_loader_if.sv
// Instruction-memory write port driven by the loader.
interface uart_inst_loader_if;
    logic        we;
    logic [7:0]  waddr;
    logic [31:0] wdata;

    modport master (output we, output waddr, output wdata);
    modport slave  (input  we, input  waddr, input  wdata);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: rxd synchronizer, start-bit qualification, mid-bit sampling.
//   state | meaning
//   IDLE  | line idle, watching for a falling edge
//   START | half-bit wait, confirm start bit still low
//   DATA  | sample 8 data bits LSB first at bit centres
//   STOP  | sample stop bit, emit byte_valid or frame_error
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_error
);

    localparam int               TMR_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TMR_W-1:0] FULL_TC = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [TMR_W-1:0] HALF_TC = TMR_W'(CLKS_PER_BIT / 2 - 1);

    logic             rxd_meta, rxd_sync, rxd_prev;
    rx_state_t        state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             byte_valid_d, frame_error_d;

    assign rx_byte = shreg_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta    <= 1'b1;
            rxd_sync    <= 1'b1;
            rxd_prev    <= 1'b1;
            state_q     <= IDLE;
            tmr_q       <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            byte_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            rxd_meta    <= rxd;
            rxd_sync    <= rxd_meta;
            rxd_prev    <= rxd_sync;
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            byte_valid  <= byte_valid_d;
            frame_error <= frame_error_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        tmr_d         = tmr_q;
        bit_d         = bit_q;
        shreg_d       = shreg_q;
        byte_valid_d  = 1'b0;
        frame_error_d = 1'b0;
        if (state_q != IDLE) tmr_d = tmr_q - TMR_W'(1);
        case (state_q)
            IDLE: begin
                if (rxd_prev && !rxd_sync) begin
                    state_d = START;
                    tmr_d   = HALF_TC;
                end
            end
            START: begin
                if (tmr_q == '0) begin
                    if (!rxd_sync) begin
                        state_d = DATA;
                        tmr_d   = FULL_TC;
                        bit_d   = '0;
                    end else begin
                        state_d = IDLE;
                        tmr_d   = '0;
                    end
                end
            end
            DATA: begin
                if (tmr_q == '0) begin
                    shreg_d = {rxd_sync, shreg_q[7:1]};
                    tmr_d   = FULL_TC;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (tmr_q == '0) begin
                    state_d       = IDLE;
                    tmr_d         = '0;
                    byte_valid_d  = rxd_sync;
                    frame_error_d = !rxd_sync;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_inst_loader.sv
// Loads a length-prefixed little-endian instruction image from UART into instruction memory.
//   state    | meaning
//   WAIT_LEN | expecting the word-count byte
//   RECV     | assembling the current 32-bit word
//   WRITE    | write strobe cycle, advance word index
//   DONE     | image loaded, further bytes ignored
module uart_inst_loader
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int MAX_WORDS    = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rxd,
    uart_inst_loader_if.master        imem,
    output logic                      busy,
    output logic                      done,
    output logic                      frame_err,
    output logic                      len_err
);

    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    logic [7:0]       rx_byte;
    logic             rx_valid, rx_frame_error;

    ld_state_t        state_q, state_d;
    logic [CNT_W-1:0] n_words_q, n_words_d;
    logic [CNT_W-1:0] word_idx_q, word_idx_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [31:0]      word_buf_q, word_buf_d;
    logic             we_d;
    logic [7:0]       waddr_d;
    logic [31:0]      wdata_d;
    logic             busy_d, done_d, frame_err_d, len_err_d;
    logic             len_ok;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk         (clk),
        .rst         (rst),
        .rxd         (rxd),
        .rx_byte     (rx_byte),
        .byte_valid  (rx_valid),
        .frame_error (rx_frame_error)
    );

    assign len_ok = (rx_byte != 8'd0) && (int'(rx_byte) <= MAX_WORDS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= WAIT_LEN;
            n_words_q  <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            word_buf_q <= '0;
            imem.we    <= 1'b0;
            imem.waddr <= '0;
            imem.wdata <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            frame_err  <= 1'b0;
            len_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_words_q  <= n_words_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            word_buf_q <= word_buf_d;
            imem.we    <= we_d;
            imem.waddr <= waddr_d;
            imem.wdata <= wdata_d;
            busy       <= busy_d;
            done       <= done_d;
            frame_err  <= frame_err_d;
            len_err    <= len_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        n_words_d   = n_words_q;
        word_idx_d  = word_idx_q;
        byte_idx_d  = byte_idx_q;
        word_buf_d  = word_buf_q;
        we_d        = 1'b0;
        waddr_d     = imem.waddr;
        wdata_d     = imem.wdata;
        busy_d      = busy;
        done_d      = done;
        frame_err_d = frame_err | rx_frame_error;
        len_err_d   = len_err;
        case (state_q)
            WAIT_LEN: begin
                if (rx_valid) begin
                    if (len_ok) begin
                        n_words_d  = CNT_W'(rx_byte);
                        word_idx_d = '0;
                        byte_idx_d = '0;
                        word_buf_d = '0;
                        busy_d     = 1'b1;
                        state_d    = RECV;
                    end else begin
                        len_err_d = 1'b1;
                    end
                end
            end
            RECV: begin
                // a bad frame mid-image abandons the load; earlier writes stand
                if (rx_frame_error) begin
                    state_d    = WAIT_LEN;
                    busy_d     = 1'b0;
                    byte_idx_d = '0;
                    word_buf_d = '0;
                end else if (rx_valid) begin
                    word_buf_d[{byte_idx_q, 3'b000} +: 8] = rx_byte;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = WRITE;
                        we_d    = 1'b1;
                        waddr_d = 8'(word_idx_q) << 2;
                        wdata_d = {rx_byte, word_buf_q[23:0]};
                    end
                end
            end
            WRITE: begin
                word_idx_d = word_idx_q + CNT_W'(1);
                byte_idx_d = '0;
                word_buf_d = '0;
                if (word_idx_q + CNT_W'(1) == n_words_q) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = RECV;
                end
            end
            DONE: ;
            default: state_d = WAIT_LEN;
        endcase
    end

endmodule

// File: tb/tb_uart_inst_loader.sv
// Scoreboard bench: expected memory writes are queued as bytes are sent and checked on each we strobe.
module tb_uart_inst_loader;

    localparam int CPB  = 8;
    localparam int MAXW = 64;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd = 1'b1;
    logic busy, done, frame_err, len_err;

    uart_inst_loader_if imem ();

    uart_inst_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(MAXW)) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .imem      (imem),
        .busy      (busy),
        .done      (done),
        .frame_err (frame_err),
        .len_err   (len_err)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    wr_t  exp_q[$];
    logic we_prev  = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (rst) begin
            we_prev <= 1'b0;
        end else begin
            we_prev <= imem.we;
            if (imem.we) begin
                check_val("we_width", 32'(we_prev), 0);
                check_val("we_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_val("waddr", 32'(imem.waddr), 32'(e.addr));
                    check_val("wdata", imem.wdata, e.data);
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        rxd = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_bit);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_word(input logic [7:0] addr, input logic [31:0] w);
        exp_q.push_back({addr, w});
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic do_reset();
        rxd = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic settle();
        repeat (20) @(negedge clk);
        check_val("pending_writes", exp_q.size(), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_we"},        32'(imem.we),    0);
        check_val({tag, "_waddr"},     32'(imem.waddr), 0);
        check_val({tag, "_wdata"},     imem.wdata,      0);
        check_val({tag, "_busy"},      32'(busy),       0);
        check_val({tag, "_done"},      32'(done),       0);
        check_val({tag, "_frame_err"}, 32'(frame_err),  0);
        check_val({tag, "_len_err"},   32'(len_err),    0);
    endtask

    initial begin
        logic [31:0] wtab [3];
        wtab[0] = 32'h0000_0013;
        wtab[1] = 32'hDEAD_BEEF;
        wtab[2] = 32'h1234_5678;

        do_reset();
        check_idle_outputs("reset");

        // single word image
        send_byte(8'h01);
        check_val("single_busy_mid", 32'(busy), 1);
        send_word(8'h00, 32'h0050_0093);
        settle();
        check_val("single_done", 32'(done), 1);
        check_val("single_busy", 32'(busy), 0);

        // three word image, done only after the last
        do_reset();
        send_byte(8'h03);
        send_word(8'h00, wtab[0]);
        send_word(8'h04, wtab[1]);
        check_val("three_done_early", 32'(done), 0);
        send_word(8'h08, wtab[2]);
        settle();
        check_val("three_done", 32'(done), 1);
        check_val("three_busy", 32'(busy), 0);
        send_byte(8'hAA);
        send_byte(8'hBB);
        repeat (10) @(negedge clk);
        check_val("done_ignores_we", 32'(imem.we), 0);

        // illegal lengths, loader must still accept a good one afterwards
        do_reset();
        send_byte(8'h00);
        check_val("len0_err", 32'(len_err), 1);
        check_val("len0_busy", 32'(busy), 0);
        send_byte(8'h41);
        check_val("len65_err", 32'(len_err), 1);
        check_val("len65_busy", 32'(busy), 0);
        check_val("len65_done", 32'(done), 0);
        send_byte(8'h40);
        check_val("len64_busy", 32'(busy), 1);

        // frame error mid-image aborts, next length restarts at address 0
        do_reset();
        send_byte(8'h02);
        send_word(8'h00, 32'hCAFE_F00D);
        check_val("ferr_busy_before", 32'(busy), 1);
        send_byte(8'h5A, 1'b0);
        check_val("ferr_flag", 32'(frame_err), 1);
        check_val("ferr_busy", 32'(busy), 0);
        check_val("ferr_done", 32'(done), 0);
        check_val("ferr_len_err", 32'(len_err), 0);
        send_byte(8'h01);
        send_word(8'h00, 32'h0BAD_C0DE);
        settle();
        check_val("ferr_restart_done", 32'(done), 1);
        check_val("ferr_sticky", 32'(frame_err), 1);

        // reset in the middle of a word
        do_reset();
        send_byte(8'h02);
        send_word(8'h00, 32'h7654_3210);
        send_byte(8'h11);
        send_byte(8'h22);
        check_val("midrst_busy_before", 32'(busy), 1);
        do_reset();
        check_idle_outputs("midrst");
        send_byte(8'h01);
        send_word(8'h00, 32'hA5A5_5A5A);
        settle();
        check_val("midrst_done", 32'(done), 1);

        // short low glitch must not start a byte
        do_reset();
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        rxd = 1'b1;
        repeat (120) @(negedge clk);
        check_val("glitch_len_err", 32'(len_err), 0);
        check_val("glitch_frame_err", 32'(frame_err), 0);
        check_val("glitch_busy", 32'(busy), 0);
        send_byte(8'h01);
        check_val("glitch_then_len", 32'(busy), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_inst_loader.md
UART_INST_LOADER -- requirements
Module: uart_inst_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clock cycles per UART bit (50 MHz / 115200).
REQ-002 SHALL have parameter MAX_WORDS, default 64, meaning instruction-memory capacity in 32-bit words.
REQ-003 SHALL have port clk, input, 1, meaning the single system clock; all logic runs on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-005 SHALL have port rxd, input, 1, meaning UART serial input (8N1, idle high), asynchronous to clk.
REQ-006 SHALL have port we, output, 1, meaning instruction-memory write strobe.
REQ-007 SHALL have port waddr, output, 8, meaning byte address of the write, matching the PC width.
REQ-008 SHALL have port wdata, output, 32, meaning the instruction word to write.
REQ-009 SHALL have port busy, output, 1, meaning a load is in progress; the CPU is held while it is high.
REQ-010 SHALL have port done, output, 1, meaning the load is complete.
REQ-011 SHALL have port frame_err, output, 1, meaning sticky flag for a bad stop bit.
REQ-012 SHALL have port len_err, output, 1, meaning sticky flag for an illegal length byte.

Function
REQ-013 SHALL pass rxd through a 2-flop synchronizer before any use.
REQ-014 SHALL implement the RX FSM states IDLE, START, DATA, STOP.
- IDLE->START on a synchronized falling edge.
- START->DATA if the line is still low CLKS_PER_BIT/2 cycles later; otherwise START->IDLE (false start).
REQ-015 SHALL sample data bits LSB first, one every CLKS_PER_BIT cycles from the start-bit midpoint.
REQ-016 SHALL sample the stop bit one CLKS_PER_BIT after data bit 7.
- Stop bit high: a 1-cycle internal byte_valid pulse on the next cycle.
- Stop bit low: the byte is discarded and frame_err is set.
- Either case: the RX FSM returns to IDLE.
REQ-017 SHALL implement the loader FSM states WAIT_LEN, RECV, WRITE, DONE.
REQ-018 In WAIT_LEN, the first valid byte is the word count N.
- N in 1..MAX_WORDS: store N, clear the word and byte counters, go to RECV, raise busy.
- N=0 or N>MAX_WORDS: set len_err and stay in WAIT_LEN.
REQ-019 In RECV, SHALL assemble bytes little-endian: byte k goes to bits [8k+7:8k].
REQ-020 On the 4th byte, SHALL go to WRITE and assert we for exactly one cycle, the cycle after that byte_valid.
- waddr = 4*word_index.
- wdata = the assembled word.
REQ-021 After WRITE, SHALL increment word_index and return to RECV if words remain.
- Otherwise go to DONE: busy low and done high from the next cycle, held until rst.
REQ-022 In DONE, SHALL ignore all further bytes; we stays low.
REQ-023 A frame error during RECV SHALL abort the load.
- Discard the partial word, return to WAIT_LEN, drop busy.
- Words already written stay written; done stays low.
REQ-024 waddr SHALL never wrap: the maximum address is 4*(MAX_WORDS-1), which is 252 at the default.
REQ-025 When a byte_valid and an RX error fall in the same cycle, SHALL act on the error only; by construction the two are exclusive.
REQ-026 frame_err and len_err SHALL clear only on rst.
REQ-027 we, waddr and wdata SHALL be registered outputs.

Reset
REQ-028 While rst=1 at a clk edge, SHALL set both FSMs to IDLE/WAIT_LEN and clear all counters.
- Outputs: we=0, waddr=0, wdata=0, busy=0, done=0, frame_err=0, len_err=0.
REQ-029 A reset mid-byte or mid-word SHALL discard all partial data; the first byte after reset is a length byte.

Structure
REQ-030 SHALL place the RX and loader state encodings and the default CLKS_PER_BIT in the shared package loader_pkg.
REQ-031 SHALL instantiate one sub-module uart_rx (synchronizer + RX FSM, outputs byte, byte_valid, frame_error); uart_inst_loader holds the loader FSM.

Verification (CLKS_PER_BIT=8)
REQ-032 Send 0x01, 0x93, 0x00, 0x50, 0x00 -> one we pulse with waddr=0x00 and wdata=0x00500093; done=1 the next cycle; busy=0.
REQ-033 Send N=0x03 plus 12 bytes -> we pulses at waddr 0x00, 0x04, 0x08 with the correct words; done high after the third.
REQ-034 Send 0x00, then 0x41 -> len_err=1, no we, still in WAIT_LEN.
REQ-035 Send N=2 and one full word, then a byte with stop bit 0 -> one write at 0x00, frame_err=1, busy=0; a new length byte restarts at waddr 0x00.
REQ-036 Low glitch of 2 cycles on rxd -> no byte accepted, no flags.
REQ-037 Assert rst after 2 bytes of a word -> all outputs 0; a subsequent 0x01 plus 4 bytes writes at waddr 0x00.
